// File: rtl/vga_fb_pkg.sv
// Shared framebuffer geometry, widths and clear-engine state encoding for the
// 160x120x8 VGA framebuffer arbiter.
package vga_fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = 19200;
  localparam int ADDR_W   = 15;
  localparam int PIX_W    = 8;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

  // row*160 + col without a multiplier: row*128 + row*32 + col
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] row,
                                                input logic [7:0] col);
    logic [ADDR_W-1:0] r;
    r       = ADDR_W'(row);
    fb_addr = (r << 7) + (r << 5) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_fb_scan_addr.sv
// Combinational decode of the timing counter into the scanout prefetch slot
// and its framebuffer address; the slot leads the visible pixel by 4 clocks.
module vga_fb_scan_addr
  import vga_fb_pkg::*;
#(
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35
) (
  input  logic [9:0]        hpixel,
  input  logic [9:0]        vpixel,
  output logic [9:0]        rel_h,
  output logic              vact,
  output logic              h_win,
  output logic              scan_slot,
  output logic [ADDR_W-1:0] scan_addr
);

  localparam logic [9:0] H_OFS   = 10'(H_ACT_START - 4);
  localparam logic [9:0] V_START = 10'(V_ACT_START);
  localparam logic [9:0] V_END   = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [9:0] H_LEN   = 10'(H_ACTIVE);

  logic [9:0] v_rel;
  logic [6:0] row;
  logic [7:0] col;

  always_comb begin
    rel_h     = hpixel - H_OFS;
    v_rel     = vpixel - V_START;
    vact      = (vpixel >= V_START) && (vpixel < V_END);
    h_win     = (rel_h < H_LEN);
    scan_slot = vact && h_win && (rel_h[1:0] == 2'b00);
    row       = 7'(v_rel >> 2);
    col       = 8'(rel_h >> 2);
    scan_addr = fb_addr(row, col);
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout prefetch > clear engine > host,
// plus the clear FSM and the zero-latency pixel output pipeline.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic [9:0]        hpixel,
  input  logic [9:0]        vpixel,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [PIX_W-1:0]  host_wdata,
  output logic              host_ack,
  output logic [PIX_W-1:0]  host_rdata,
  output logic              host_rvalid,
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pix_rgb,
  output logic              pix_active
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(FB_DEPTH);
  localparam logic [9:0]        PIX_LO    = 10'd3;
  localparam logic [9:0]        PIX_HI    = 10'(H_ACTIVE + 2);

  logic [9:0]        rel_h;
  logic              vact;
  logic              h_win;
  logic              scan_slot;
  logic [ADDR_W-1:0] scan_addr;

  clr_state_t        clr_state, clr_state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [PIX_W-1:0]  clr_color_q, clr_color_nxt;

  logic gnt_scan, gnt_clr, gnt_host, host_oor;
  logic pix_win, pix_load;

  logic             scan_vld_p1;
  logic [PIX_W-1:0] fetch_p1;
  logic             rd_vld_p1;
  logic             rd_oor_p1;

  vga_fb_scan_addr #(
    .H_ACT_START(H_ACT_START),
    .V_ACT_START(V_ACT_START)
  ) u_scan_addr (
    .hpixel   (hpixel),
    .vpixel   (vpixel),
    .rel_h    (rel_h),
    .vact     (vact),
    .h_win    (h_win),
    .scan_slot(scan_slot),
    .scan_addr(scan_addr)
  );

  // Grants are combinational and forced off while rst is held so every
  // RAM/host output reads 0 for the whole reset, not just after an edge.
  always_comb begin
    host_oor = (host_addr >= DEPTH_A);
    gnt_scan = scan_slot && !rst;
    gnt_clr  = !scan_slot && (clr_state == CLR_CLEAR) && !rst;
    gnt_host = host_req && !scan_slot && (clr_state == CLR_IDLE) && !rst;
    host_ack = gnt_host;
    clr_busy = (clr_state == CLR_CLEAR);
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_scan) begin
      ram_en   = 1'b1;
      ram_addr = scan_addr;
    end else if (gnt_clr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt;
      ram_wdata = clr_color_q;
    end else if (gnt_host && !host_oor) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_we ? host_wdata : '0;
    end
  end

  always_comb begin
    clr_state_nxt = clr_state;
    clr_cnt_nxt   = clr_cnt;
    clr_color_nxt = clr_color_q;
    unique case (clr_state)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_nxt = CLR_CLEAR;
          clr_cnt_nxt   = '0;
          clr_color_nxt = clr_color;
        end
      end
      CLR_CLEAR: begin
        if (gnt_clr) begin
          if (clr_cnt == LAST_ADDR) begin
            clr_state_nxt = CLR_IDLE;
            clr_cnt_nxt   = '0;
          end else begin
            clr_cnt_nxt = clr_cnt + 1'b1;
          end
        end
      end
      default: clr_state_nxt = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      clr_state   <= CLR_IDLE;
      clr_cnt     <= '0;
      clr_color_q <= '0;
    end else begin
      clr_state   <= clr_state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      clr_color_q <= clr_color_nxt;
    end
  end

  // The output window runs one count ahead of hpixel so pix_rgb changes on
  // the same edge the counter enters/leaves H_ACT_START..H_ACT_START+639.
  always_comb begin
    pix_win  = vact && (rel_h >= PIX_LO) && (rel_h <= PIX_HI);
    pix_load = h_win && (rel_h[1:0] == 2'b11);
  end

  // p1: RAM read data returns for the scan slot or host read issued last cycle
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      scan_vld_p1 <= 1'b0;
      fetch_p1    <= '0;
      rd_vld_p1   <= 1'b0;
      rd_oor_p1   <= 1'b0;
    end else begin
      scan_vld_p1 <= gnt_scan;
      rd_vld_p1   <= gnt_host && !host_we;
      rd_oor_p1   <= host_oor;
      if (scan_vld_p1) begin
        fetch_p1 <= ram_rdata;
      end
    end
  end

  // p2: fetched pixel moves to the output register at the 4-pixel boundary
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      pix_rgb    <= '0;
      pix_active <= 1'b0;
    end else if (pix_win) begin
      pix_active <= 1'b1;
      if (pix_load) begin
        pix_rgb <= fetch_p1;
      end
    end else begin
      pix_rgb    <= '0;
      pix_active <= 1'b0;
    end
  end

  always_comb begin
    host_rvalid = rd_vld_p1;
    host_rdata  = (rd_vld_p1 && !rd_oor_p1) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a behavioural synchronous RAM and
// a TB-driven timing counter that visits a subset of lines per frame.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int HS = 144;
  localparam int VS = 35;

  logic              clk_25 = 1'b0;
  logic              rst = 1'b1;
  logic [9:0]        hpixel = '0;
  logic [9:0]        vpixel = '0;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [PIX_W-1:0]  host_wdata = '0;
  logic              host_ack;
  logic [PIX_W-1:0]  host_rdata;
  logic              host_rvalid;
  logic              clr_start = 1'b0;
  logic [PIX_W-1:0]  clr_color = '0;
  logic              clr_busy;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  ram_rdata = '0;
  logic [PIX_W-1:0]  pix_rgb;
  logic              pix_active;

  always #5 clk_25 = ~clk_25;

  vga_fb_arbiter #(.H_ACT_START(HS), .V_ACT_START(VS)) dut (
    .clk_25(clk_25), .rst(rst), .hpixel(hpixel), .vpixel(vpixel),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pix_rgb(pix_rgb),
    .pix_active(pix_active)
  );

  logic [7:0] mem    [0:FB_DEPTH-1];
  logic [7:0] ref_fb [0:FB_DEPTH-1];
  int ram_oob = 0;

  always @(posedge clk_25) begin
    if (ram_en) begin
      if (int'(ram_addr) < FB_DEPTH) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
      end else begin
        ram_oob <= ram_oob + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_pix(input logic [9:0] h, input logic [9:0] v);
    int a;
    if (int'(h) >= HS && int'(h) <= HS + 639 && int'(v) >= VS && int'(v) <= VS + 479) begin
      a = ((int'(v) - VS) / 4) * 160 + (int'(h) - HS) / 4;
      return {1'b1, ref_fb[a]};
    end
    return 9'd0;
  endfunction

  // Scoreboards: host read data expected at ack, pixel expected at counter drive
  logic [7:0] rd_q[$];
  logic [8:0] pix_q[$];
  int  busy_cnt = 0, clr_wr = 0, clr_bad = 0, acks = 0, ack_busy = 0;
  int  clr_exp_addr = 0;
  logic [7:0] clr_exp_color = 8'h5A;
  bit  rv_exp = 1'b0;

  always @(negedge clk_25) begin
    if (clr_busy) busy_cnt++;
    if (ram_en && ram_we && clr_busy) begin
      if (int'(ram_addr) != clr_exp_addr || ram_wdata !== clr_exp_color) clr_bad++;
      clr_exp_addr++;
      clr_wr++;
    end
    if (host_rvalid || rv_exp) begin
      chk("rvalid_timing", host_rvalid, rv_exp);
      if (host_rvalid) begin
        chk("rd_q_size", rd_q.size(), 1);
        if (rd_q.size() > 0) chk("host_rdata", host_rdata, rd_q.pop_front());
      end
    end
    rv_exp = host_ack && !host_we;
    if (host_ack) begin
      acks++;
      if (clr_busy) ack_busy++;
      if (int'(host_addr) >= FB_DEPTH) chk("oor_ram_en", ram_en, 0);
      if (!host_we) rd_q.push_back(int'(host_addr) < FB_DEPTH ? ref_fb[host_addr] : 8'h00);
    end
  end

  int lines[$] = '{0, 33, 34, 35, 36, 37, 38, 39, 40, 41, 42, 43, 200, 513, 514, 515, 524};
  int li = 0;
  bit run = 1'b0;
  bit scan_chk = 1'b0;

  task automatic step();
    logic [8:0] e;
    @(posedge clk_25);
    #1;
    if (run) begin
      if (hpixel == 10'd799) begin
        hpixel = '0;
        li++;
        vpixel = (li < lines.size()) ? 10'(lines[li]) : 10'd0;
      end else begin
        hpixel = hpixel + 10'd1;
      end
    end
    if (scan_chk) pix_q.push_back(exp_pix(hpixel, vpixel));
    #1;
    if (scan_chk) begin
      e = pix_q.pop_front();
      chk("pix_active", pix_active, e[8]);
      chk("pix_rgb", pix_rgb, e[7:0]);
    end
  endtask

  task automatic host_op(input logic we, input int addr, input logic [7:0] wd);
    bit got;
    got        = 1'b0;
    host_we    = we;
    host_addr  = ADDR_W'(addr);
    host_wdata = wd;
    host_req   = 1'b1;
    for (int i = 0; i < 40000 && !got; i++) begin
      #1;
      if (host_ack) got = 1'b1;
      step();
    end
    host_req = 1'b0;
    chk("host_ack_seen", got, 1);
    if (we && addr < FB_DEPTH) ref_fb[addr] = wd;
  endtask

  task automatic scan_frame();
    li = 0; hpixel = '0; vpixel = 10'(lines[0]);
    run = 1'b1; scan_chk = 1'b1;
    while (li < lines.size()) begin
      step();
      if (vpixel == 10'd36 && hpixel == 10'd148) begin
        host_we = 1'b0; host_addr = '0; host_req = 1'b1;
        #1;
        chk("coll_no_ack", host_ack, 0);
        chk("coll_scan_addr", ram_addr, 2);
        chk("coll_scan_we", ram_we, 0);
        step();
        #1;
        chk("coll_ack_next", host_ack, 1);
        chk("coll_host_addr", ram_addr, 0);
        step();
        host_req = 1'b0;
      end
    end
    run = 1'b0; scan_chk = 1'b0; hpixel = '0; vpixel = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks0;
    for (int i = 0; i < FB_DEPTH; i++) begin mem[i] = 8'h00; ref_fb[i] = 8'h00; end
    // Reset with a pending host request, a start pulse and the counter on a slot
    host_req = 1'b1; host_addr = 15'd7; clr_start = 1'b1; clr_color = 8'h33;
    hpixel = 10'd140; vpixel = 10'd35;
    repeat (3) @(posedge clk_25);
    #1;
    chk("rst_host_ack", host_ack, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_pix_rgb", pix_rgb, 0);
    chk("rst_pix_active", pix_active, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 0);
    host_req = 1'b0; clr_start = 1'b0; hpixel = '0; vpixel = '0;
    @(posedge clk_25); #1 rst = 1'b0;
    repeat (3) step();
    chk("post_rst_acks", acks, 0);

    // Clear to 0x5A with the counter parked in blanking
    busy_cnt = 0; clr_wr = 0; clr_bad = 0; clr_exp_addr = 0; clr_exp_color = 8'h5A;
    clr_color = 8'h5A; clr_start = 1'b1;
    #1 chk("busy_before_edge", clr_busy, 0);
    step();
    clr_start = 1'b0; clr_color = 8'h11;
    #1 chk("busy_rise", clr_busy, 1);
    for (int i = 0; i < FB_DEPTH; i++) ref_fb[i] = 8'h5A;
    repeat (200) step();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    host_op(1'b0, 5, 8'h00);
    repeat (4) step();
    chk("clr_busy_len", busy_cnt, 19200);
    chk("clr_writes", clr_wr, 19200);
    chk("clr_bad_writes", clr_bad, 0);
    chk("ack_during_busy", ack_busy, 0);
    repeat (20) step();
    chk("second_start_ignored", busy_cnt, 19200);
    chk("busy_low", clr_busy, 0);

    // Host write/read, out-of-range, back-to-back
    host_op(1'b1, 161, 8'hC3);
    host_op(1'b0, 161, 8'h00);
    host_op(1'b1, 19200, 8'h77);
    host_op(1'b0, 19200, 8'h00);
    repeat (3) step();
    chk("mem_161", mem[161], 8'hC3);
    acks0 = acks;
    host_we = 1'b0; host_addr = 15'd161; host_req = 1'b1;
    repeat (3) step();
    host_req = 1'b0;
    repeat (3) step();
    chk("b2b_acks", acks - acks0, 3);

    // Scanout over sampled lines with a collision on a scan slot
    scan_frame();
    repeat (3) step();
    chk("rd_q_drained", rd_q.size(), 0);

    // Reset in the middle of a clear
    clr_exp_addr = 0; clr_exp_color = 8'hA5;
    clr_color = 8'hA5; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (500) step();
    #1 chk("midclr_busy", clr_busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", clr_busy, 0);
    chk("midrst_ram_en", ram_en, 0);
    chk("midrst_ram_we", ram_we, 0);
    chk("midrst_ram_wdata", ram_wdata, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    chk("midrst_host_ack", host_ack, 0);
    chk("midrst_pix", {pix_active, pix_rgb}, 0);
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    chk("after_rst_busy", clr_busy, 0);
    chk("partial_mem_0", mem[0], 8'hA5);
    chk("partial_mem_19000", mem[19000], 8'h5A);
    chk("ram_oob", ram_oob, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
